// File: rtl/sa_skew_feeder.sv
// Operand feeder for an NxN 8-bit systolic array: buffers A rows / B columns, then
// streams them diagonally skewed. Define SA_FEEDER_PERF_EN to add the perf_cnt output.
module sa_skew_feeder #(
  parameter int N         = 8,
  parameter int DRAIN_CYC = 16
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           ld_valid,
  output logic           ld_ready,
  input  logic [N*8-1:0] ld_a_row,
  input  logic [N*8-1:0] ld_b_col,
  output logic [N*8-1:0] a_out,
  output logic [N*8-1:0] b_out,
  output logic           sa_clr,
  output logic           busy,
`ifdef SA_FEEDER_PERF_EN
  output logic [31:0]    perf_cnt,
`endif
  output logic           done
);

  localparam int KW = (N > 1) ? $clog2(N) : 1;
  localparam int TW = $clog2(2 * N);
  localparam int DW = (DRAIN_CYC > 1) ? $clog2(DRAIN_CYC) : 1;

  typedef enum logic [2:0] {
    S_LOAD,
    S_CLEAR,
    S_STREAM,
    S_DRAIN,
    S_DONE
  } state_t;

  state_t          state, state_nxt;
  logic [KW-1:0]   k, k_nxt;
  logic [TW-1:0]   t, t_nxt;
  logic [DW-1:0]   drn, drn_nxt;
  logic            ld_ready_nxt, sa_clr_nxt, done_nxt, stream_en;
  logic [N*8-1:0]  a_nxt, b_nxt;
  logic            accept;
  int              d;

  logic [7:0] abuf [N][N];
  logic [7:0] bbuf [N][N];

  assign accept = (state == S_LOAD) && ld_valid && ld_ready;

  // NOTE: every signal assigned in an always_comb gets a default first so no latch is inferred.
  always_comb begin
    state_nxt    = state;
    k_nxt        = k;
    t_nxt        = t;
    drn_nxt      = drn;
    ld_ready_nxt = 1'b0;
    sa_clr_nxt   = 1'b0;
    done_nxt     = 1'b0;
    stream_en    = 1'b0;
    unique case (state)
      S_LOAD: begin
        ld_ready_nxt = 1'b1;
        if (accept) begin
          k_nxt = k + 1'b1;
          if (k == KW'(N - 1)) begin
            state_nxt    = S_CLEAR;
            k_nxt        = '0;
            ld_ready_nxt = 1'b0;
            sa_clr_nxt   = 1'b1;
          end
        end
      end
      S_CLEAR: begin
        state_nxt = S_STREAM;
        t_nxt     = '0;
        stream_en = 1'b1;
      end
      S_STREAM: begin
        if (t == TW'(2 * N - 2)) begin
          state_nxt = S_DRAIN;
          drn_nxt   = '0;
        end else begin
          t_nxt     = t + 1'b1;
          stream_en = 1'b1;
        end
      end
      S_DRAIN: begin
        if (drn == DW'(DRAIN_CYC - 1)) begin
          state_nxt = S_DONE;
          done_nxt  = 1'b1;
        end else begin
          drn_nxt = drn + 1'b1;
        end
      end
      S_DONE: begin
        state_nxt    = S_LOAD;
        k_nxt        = '0;
        ld_ready_nxt = 1'b1;
      end
      default: state_nxt = S_LOAD;
    endcase
  end

  // Skewed operands for stream step t_nxt: lane i carries element (t - i) of its row/column.
  always_comb begin
    a_nxt = '0;
    b_nxt = '0;
    d     = 0;
    if (stream_en) begin
      for (int i = 0; i < N; i++) begin
        d = int'(t_nxt) - i;
        if (d >= 0 && d < N) begin
          a_nxt[8*i +: 8] = abuf[i][d[KW-1:0]];
          b_nxt[8*i +: 8] = bbuf[d[KW-1:0]][i];
        end
      end
    end
  end

  // NOTE: state is updated with non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state    <= S_LOAD;
      k        <= '0;
      t        <= '0;
      drn      <= '0;
      ld_ready <= 1'b0;
      a_out    <= '0;
      b_out    <= '0;
      sa_clr   <= 1'b1;
      busy     <= 1'b0;
      done     <= 1'b0;
    end else begin
      state    <= state_nxt;
      k        <= k_nxt;
      t        <= t_nxt;
      drn      <= drn_nxt;
      ld_ready <= ld_ready_nxt;
      a_out    <= a_nxt;
      b_out    <= b_nxt;
      sa_clr   <= sa_clr_nxt;
      busy     <= (state_nxt != S_LOAD);
      done     <= done_nxt;
    end
  end

  // NOTE: the operand banks have no reset; a full load rewrites every byte before it is streamed.
  always_ff @(posedge clk) begin
    if (accept) begin
      for (int m = 0; m < N; m++) begin
        abuf[k][m] <= ld_a_row[8*m +: 8];
        bbuf[m][k] <= ld_b_col[8*m +: 8];
      end
    end
  end

`ifdef SA_FEEDER_PERF_EN
  always_ff @(posedge clk) begin
    if (!rst) begin
      perf_cnt <= '0;
    end else if (done_nxt) begin
      perf_cnt <= perf_cnt + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_sa_skew_feeder.sv
// Self-checking bench for sa_skew_feeder: cycle trace against the documented timeline and an
// ideal downstream array whose result is compared with a plain matrix product.
module tb_sa_skew_feeder;

  localparam int N         = 8;
  localparam int DRAIN_CYC = 16;
  localparam int LAT       = 32;  // edges from last-beat acceptance to the done pulse

  logic           clk = 1'b0;
  logic           rst = 1'b0;
  logic           ld_valid = 1'b0;
  logic           ld_ready;
  logic [N*8-1:0] ld_a_row = '0;
  logic [N*8-1:0] ld_b_col = '0;
  logic [N*8-1:0] a_out, b_out;
  logic           sa_clr, busy, done;
`ifdef SA_FEEDER_PERF_EN
  logic [31:0]    perf_cnt;
`endif

  sa_skew_feeder #(.N(N), .DRAIN_CYC(DRAIN_CYC)) dut (
    .clk      (clk),
    .rst      (rst),
    .ld_valid (ld_valid),
    .ld_ready (ld_ready),
    .ld_a_row (ld_a_row),
    .ld_b_col (ld_b_col),
    .a_out    (a_out),
    .b_out    (b_out),
    .sa_clr   (sa_clr),
    .busy     (busy),
`ifdef SA_FEEDER_PERF_EN
    .perf_cnt (perf_cnt),
`endif
    .done     (done)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int exp_perf = 0;

  logic [7:0]     mat_a [N][N];
  logic [7:0]     mat_b [N][N];
  logic [N*8-1:0] cap_a [2*N-1];
  logic [N*8-1:0] cap_b [2*N-1];

  // Ideal downstream array: A moves east, B moves south, each PE accumulates mod 2^16.
  logic [7:0]  pa [N][N];
  logic [7:0]  pb [N][N];
  logic [15:0] pc [N][N];

  function automatic logic [7:0] west(input int i, input int j);
    if (j == 0) return a_out[8*i +: 8];
    return pa[i][j-1];
  endfunction

  function automatic logic [7:0] north(input int i, input int j);
    if (i == 0) return b_out[8*j +: 8];
    return pb[i-1][j];
  endfunction

  always @(posedge clk) begin
    for (int i = 0; i < N; i++) begin
      for (int j = 0; j < N; j++) begin
        if (sa_clr) begin
          pa[i][j] <= '0;
          pb[i][j] <= '0;
          pc[i][j] <= '0;
        end else begin
          pa[i][j] <= west(i, j);
          pb[i][j] <= north(i, j);
          pc[i][j] <= pc[i][j] + ({8'd0, west(i, j)} * {8'd0, north(i, j)});
        end
      end
    end
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Spec rule: at stream step t, lane i of A carries A[i][t-i]; lane j of B carries B[t-j][j].
  function automatic logic [N*8-1:0] exp_a(input int t);
    logic [N*8-1:0] r = '0;
    for (int i = 0; i < N; i++)
      if (t - i >= 0 && t - i < N) r[8*i +: 8] = mat_a[i][t-i];
    return r;
  endfunction

  function automatic logic [N*8-1:0] exp_b(input int t);
    logic [N*8-1:0] r = '0;
    for (int j = 0; j < N; j++)
      if (t - j >= 0 && t - j < N) r[8*j +: 8] = mat_b[t-j][j];
    return r;
  endfunction

  function automatic logic [N*8-1:0] row_of(input int k);
    logic [N*8-1:0] r;
    for (int m = 0; m < N; m++) r[8*m +: 8] = mat_a[k][m];
    return r;
  endfunction

  function automatic logic [N*8-1:0] col_of(input int k);
    logic [N*8-1:0] r;
    for (int m = 0; m < N; m++) r[8*m +: 8] = mat_b[m][k];
    return r;
  endfunction

  task automatic check_c(input string tag);
    int s;
    for (int i = 0; i < N; i++) begin
      for (int j = 0; j < N; j++) begin
        s = 0;
        for (int m = 0; m < N; m++) s += int'(mat_a[i][m]) * int'(mat_b[m][j]);
        check($sformatf("%s_c%0d%0d", tag, i, j), 64'(pc[i][j]), 64'(s[15:0]));
      end
    end
  endtask

  task automatic set_random();
    for (int i = 0; i < N; i++)
      for (int j = 0; j < N; j++) begin
        mat_a[i][j] = 8'($urandom);
        mat_b[i][j] = 8'($urandom);
      end
  endtask

  task automatic do_reset(input int cycles);
    @(negedge clk);
    rst      = 1'b0;
    ld_valid = 1'b0;
    for (int c = 0; c < cycles; c++) begin
      @(negedge clk);
      check("rst_sa_clr", 64'(sa_clr), 64'd1);
      check("rst_ld_ready", 64'(ld_ready), 64'd0);
    end
    check("rst_a_out", 64'(a_out), 64'd0);
    check("rst_busy", 64'(busy), 64'd0);
    rst      = 1'b1;
    exp_perf = 0;
    @(negedge clk);
    check("post_rst_ld_ready", 64'(ld_ready), 64'd1);
    check("post_rst_sa_clr", 64'(sa_clr), 64'd0);
    check("post_rst_done", 64'(done), 64'd0);
  endtask

  // mode 0: back-to-back, 1: valid pattern 1,0,0 repeating, 2: random gaps.
  // Returns at the negedge where the last beat is presented; it is accepted at the next edge.
  task automatic do_load(input int mode);
    int k   = 0;
    int cyc = 0;
    bit v;
    while (k < N) begin
      @(negedge clk);
      if (cyc > 40 * N) begin
        check("load_timeout_beats", 64'(k), 64'(N));
        ld_valid = 1'b0;
        return;
      end
      case (mode)
        0:       v = 1'b1;
        1:       v = (cyc % 3 == 0);
        default: v = 1'($urandom_range(0, 1));
      endcase
      ld_valid = v;
      ld_a_row = row_of(k);
      ld_b_col = col_of(k);
      if (v && ld_ready) k++;
      cyc++;
    end
  endtask

  // Follows one multiply from the acceptance edge to the first LOAD cycle after done.
  task automatic run_trace(input bit hold_valid);
    for (int n = 0; n <= LAT + 1; n++) begin
      @(negedge clk);
      ld_valid = (n == LAT + 1) ? 1'b0 : hold_valid;
      ld_a_row = {$urandom, $urandom};
      ld_b_col = {$urandom, $urandom};
      check($sformatf("ld_ready_n%0d", n), 64'(ld_ready), 64'(n == LAT + 1));
      check($sformatf("busy_n%0d", n), 64'(busy), 64'(n <= LAT));
      check($sformatf("sa_clr_n%0d", n), 64'(sa_clr), 64'(n == 0));
      check($sformatf("done_n%0d", n), 64'(done), 64'(n == LAT));
      check($sformatf("a_out_n%0d", n), 64'(a_out), 64'(exp_a(n - 1)));
      check($sformatf("b_out_n%0d", n), 64'(b_out), 64'(exp_b(n - 1)));
      if (n >= 1 && n <= 2 * N - 1) begin
        cap_a[n-1] = a_out;
        cap_b[n-1] = b_out;
      end
      if (n == LAT) check_c("prod");
    end
    exp_perf++;
`ifdef SA_FEEDER_PERF_EN
    check("perf_cnt", 64'(perf_cnt), 64'(exp_perf));
`endif
  endtask

  typedef struct {
    int         t;
    bit         is_b;
    int         lane;
    logic [7:0] exp;
  } vec_t;

  vec_t vecs [8];

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    vecs[0] = '{3,  1'b0, 0, 8'h04};
    vecs[1] = '{3,  1'b0, 2, 8'h22};
    vecs[2] = '{3,  1'b0, 3, 8'h31};
    vecs[3] = '{3,  1'b0, 4, 8'h00};
    vecs[4] = '{14, 1'b0, 7, 8'h78};
    vecs[5] = '{14, 1'b0, 0, 8'h00};
    vecs[6] = '{3,  1'b1, 1, 8'h11};
    vecs[7] = '{14, 1'b1, 7, 8'h3f};

    // Reset held 3 cycles.
    do_reset(3);

    // Counting pattern A[i][m] = 16i+m+1, B[m][j] = 8m+j.
    for (int i = 0; i < N; i++)
      for (int j = 0; j < N; j++) begin
        mat_a[i][j] = 8'(16 * i + j + 1);
        mat_b[i][j] = 8'(8 * i + j);
      end
    do_load(0);
    run_trace(1'b0);
    for (int v = 0; v < 8; v++) begin
      logic [N*8-1:0] w;
      w = vecs[v].is_b ? cap_b[vecs[v].t] : cap_a[vecs[v].t];
      check($sformatf("vec%0d_t%0d_lane%0d", v, vecs[v].t, vecs[v].lane),
            64'(w[8*vecs[v].lane +: 8]), 64'(vecs[v].exp));
    end
    check("t14_a_full", 64'(cap_a[14]), 64'h7800_0000_0000_0000);

    // Identity times B: C must equal B and hold through idle LOAD cycles.
    for (int i = 0; i < N; i++)
      for (int j = 0; j < N; j++) begin
        mat_a[i][j] = (i == j) ? 8'd1 : 8'd0;
        mat_b[i][j] = 8'(8 * i + j);
      end
    do_load(0);
    run_trace(1'b0);
    repeat (3) @(negedge clk);
    check("idle_sa_clr", 64'(sa_clr), 64'd0);
    check("idle_a_out", 64'(a_out), 64'd0);
    check("idle_c07", 64'(pc[0][7]), 64'd7);
    check("idle_c76", 64'(pc[7][6]), 64'd62);
    check_c("hold");

    // Gappy load with ld_valid held high through the whole multiply.
    set_random();
    do_load(1);
    run_trace(1'b1);

    // Random gaps, random ld_valid activity outside LOAD.
    for (int r = 0; r < 3; r++) begin
      set_random();
      do_load(2);
      run_trace(1'($urandom_range(0, 1)));
    end

    // Reset at STREAM t=5, then a fresh load must show no residue.
    set_random();
    do_load(0);
    for (int n = 0; n <= 6; n++) begin
      @(negedge clk);
      ld_valid = 1'b0;
    end
    check("abort_pre_a", 64'(a_out), 64'(exp_a(5)));
    rst = 1'b0;
    @(negedge clk);
    check("abort_a_out", 64'(a_out), 64'd0);
    check("abort_b_out", 64'(b_out), 64'd0);
    check("abort_sa_clr", 64'(sa_clr), 64'd1);
    check("abort_busy", 64'(busy), 64'd0);
    rst      = 1'b1;
    exp_perf = 0;
    @(negedge clk);
    check("abort_ld_ready", 64'(ld_ready), 64'd1);
    set_random();
    do_load(2);
    run_trace(1'b0);

    // Second back-to-back multiply.
    set_random();
    do_load(0);
    run_trace(1'b1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
